demux_tdm_1_n: RTL and testbench
================================

Name: demux_tdm_1_n

Overview:
- Receive end of the team's N:1 serial selection path: a registered 1-to-N time-division demultiplexer.
- Takes a 1-bit serial stream, one bit per valid cycle, and routes each bit to its channel slot.
- Slot is taken from an internal slot counter (auto mode) or an explicit select (direct mode).
- Assembles a full N-bit word in a shadow register and presents it atomically on `y` with a one-cycle `frame_done` strobe.

Parameters:
- N, 4, number of output channels (≥2; need not be a power of two).
- SELW, $clog2(N), select/counter width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  `din` is valid this cycle.
- sof  in  1  start of frame; qualified by `din_valid`; marks the current bit as slot 0 (auto mode only).
- sel_mode  in  1  0 = auto slot counter, 1 = direct select.
- sel  in  SELW  target channel in direct mode.
- y  out  N  registered parallel word; bit k = channel k.
- frame_done  out  1  one-cycle pulse when `y` is updated.
- frame_err  out  1  one-cycle pulse on a protocol error.
- slot  out  SELW  current slot counter value (debug/observability).

Behaviour:
- Reset (async assert, sync-free deassert)
  - `y`, shadow, `slot`, `frame_done`, `frame_err` = 0; FSM = IDLE.
- FSM states: IDLE, RUN. All outputs are registered.
- Auto mode (`sel_mode`=0)
  - IDLE:
    - `din_valid`&`sof`: shadow[0] <= `din`; `slot` <= 1; go RUN.
    - `din_valid` without `sof`: bit dropped, no error.
  - RUN, `din_valid`&!`sof`: shadow[`slot`] <= `din`; `slot`++.
  - When the bit for slot N-1 is captured:
    - `y` <= shadow with the new bit merged; `frame_done`=1 on the next cycle; `slot` <= 0; go IDLE.
    - Latency: last bit → `y`/`frame_done` = 1 clock.
  - RUN, `din_valid`&`sof` (early sof, `slot`≠0):
    - `frame_err` pulse; partial frame discarded.
    - Current bit taken as slot 0; `slot` <= 1; stay RUN.
  - `din_valid`=0: hold all state; no timeout.
  - Counter wraps at N-1 → 0, never N (non-power-of-two N).
- Direct mode (`sel_mode`=1)
  - FSM forced to IDLE; `slot` held at 0; `sof` ignored.
  - `din_valid`: `y[sel]` <= `din` directly, other bits held; `frame_done` pulses each update (latency 1).
  - `sel` ≥ N: `y` unchanged, `frame_err` pulse, no `frame_done`.
- Mode switch from auto to direct mid-frame: partial frame discarded silently; `y` unchanged.
- Shadow bits not yet written in the current frame keep stale values; only a complete frame reaches `y` in auto mode.
- Reset mid-frame: everything cleared immediately; the next frame must start with `sof`.

Optional Feature:
- Macro: DEMUX_TDM_PARITY_EN
- Defined (auto mode):
  - Each frame carries one extra bit after slot N-1: even parity over the N data bits.
  - Extra state PAR between RUN and IDLE.
  - Parity match → `y` update + `frame_done` (latency: parity bit → 1 clock).
  - Mismatch → `frame_err`, `y` unchanged.
  - `sof` during PAR → early-sof error, same rule as RUN.
- Undefined: no parity slot and no PAR state. Direct mode is unaffected either way.

Decomposition:
- Package demux_tdm_pkg:
  - State enum `demux_state_t` {IDLE, RUN, PAR}.
  - Mode constants MODE_AUTO=1'b0, MODE_DIRECT=1'b1.
- Sub-module tdm_slot_counter:
  - Modulo-N counter with clear/load-1/enable and a terminal-count output.
  - Instantiated once.

Test Plan:
- N=4, auto mode:
  - Stream 1,0,1,1 with `sof` on bit 0 → `y`=4'b1101 one clock after bit 4, `frame_done` for exactly 1 cycle, `slot` back to 0.
  - Valid gaps: same frame with `din_valid` low for 3 cycles between bits 2 and 3 → identical result, no `frame_err`.
  - Early sof: after 2 bits, `sof` with `din`=0, then 1,1,0 → `frame_err` pulse at the restart; then `y`=4'b0110.
- N=4, direct mode:
  - `sel`=2, `din`=1 → `y`=4'b0100.
- N=3, direct mode:
  - `sel`=3 → `frame_err` pulse, `y` unchanged.
- Reset and N=5 wrap:
  - `rst_n` low after 2 of 4 bits → outputs 0 immediately; a following full frame decodes correctly.
  - N=5, two back-to-back frames → `slot` sequence 1,2,3,4,0,1,…; two `frame_done` pulses.
- With DEMUX_TDM_PARITY_EN, N=4:
  - 1,0,1,1 + parity 1 → `y`=4'b1101.
  - Same frame with parity 0 → `frame_err`, `y` unchanged.

Source files
------------

// File: rtl/demux_tdm_pkg.sv
// Shared types for the 1-to-N TDM demultiplexer: FSM state encoding and select-mode constants.
package demux_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAR  = 2'd2
  } demux_state_t;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_DIRECT = 1'b1;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N slot counter with clear, load-to-one and enable; tc flags the last slot (N-1).
module tdm_slot_counter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load1,
  input  logic            en,
  output logic [SELW-1:0] count,
  output logic            tc
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  localparam logic [SELW-1:0] ONE  = SELW'(1);

  // Explicit wrap at N-1 so a non-power-of-two N never reaches the value N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         count <= '0;
    else if (clr)       count <= '0;
    else if (load1)     count <= ONE;
    else if (en)        count <= (count == LAST) ? '0 : count + ONE;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/demux_tdm_1_n.sv
// Registered 1-to-N TDM demultiplexer with auto (slot counter) and direct (sel) routing.
// Optional trailing even-parity bit per auto-mode frame when DEMUX_TDM_PARITY_EN is defined.
module demux_tdm_1_n
  import demux_tdm_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din,
  input  logic            din_valid,
  input  logic            sof,
  input  logic            sel_mode,
  input  logic [SELW-1:0] sel,
  output logic [N-1:0]    y,
  output logic            frame_done,
  output logic            frame_err,
  output logic [SELW-1:0] slot
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  demux_state_t state, state_nxt;
  logic [N-1:0] shadow, shadow_nxt;
  logic [N-1:0] y_nxt;
  logic         done_nxt, err_nxt;
  logic         cnt_clr, cnt_load1, cnt_en, slot_tc;

  tdm_slot_counter #(.N(N), .SELW(SELW)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .en    (cnt_en),
    .count (slot),
    .tc    (slot_tc)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    y_nxt      = y;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_en     = 1'b0;

    if (sel_mode == MODE_DIRECT) begin
      // Direct routing abandons any partial auto-mode frame without reporting it.
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      if (din_valid) begin
        if ({1'b0, sel} < N_W) begin
          y_nxt[sel] = din;
          done_nxt   = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
    end else if (din_valid) begin
      if (sof) begin
        // A sof outside IDLE means the previous frame was cut short.
        err_nxt       = (state != IDLE);
        shadow_nxt[0] = din;
        cnt_load1     = 1'b1;
        state_nxt     = RUN;
      end else begin
        unique case (state)
          RUN: begin
            shadow_nxt[slot] = din;
            cnt_en           = 1'b1;
            if (slot_tc) begin
`ifdef DEMUX_TDM_PARITY_EN
              state_nxt = PAR;
`else
              y_nxt     = shadow_nxt;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
`endif
            end
          end
`ifdef DEMUX_TDM_PARITY_EN
          PAR: begin
            state_nxt = IDLE;
            if ((^shadow ^ din) == 1'b0) begin
              y_nxt    = shadow;
              done_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      y          <= y_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_demux_tdm_1_n.sv
// Directed bench for demux_tdm_1_n: N=4, N=3 and N=5 instances share stimulus; each phase checks one of them.
module tb_demux_tdm_1_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, din_valid, sof, sel_mode;
  logic [2:0] sel;

  logic [3:0] y4;
  logic [2:0] y3;
  logic [4:0] y5;
  logic       done4, err4, done3, err3, done5, err5;
  logic [1:0] slot4, slot3;
  logic [2:0] slot5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_tdm_1_n #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .sel_mode(sel_mode), .sel(sel[1:0]), .y(y4), .frame_done(done4),
    .frame_err(err4), .slot(slot4));

  demux_tdm_1_n #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .sel_mode(sel_mode), .sel(sel[1:0]), .y(y3), .frame_done(done3),
    .frame_err(err3), .slot(slot3));

  demux_tdm_1_n #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .sel_mode(sel_mode), .sel(sel), .y(y5), .frame_done(done5),
    .frame_err(err5), .slot(slot5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input vector, let one rising edge consume it, then sample 1 time unit later.
  task automatic step(input logic d, input logic v, input logic s);
    din       = d;
    din_valid = v;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int slot_exp[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int bits5[10]    = '{1, 1, 0, 0, 1, 0, 1, 0, 1, 0};
  int done_cnt;

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    sel_mode = 1'b0; sel = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_y",    y4,    4'b0000);
    check("rst_done", done4, 1'b0);
    check("rst_err",  err4,  1'b0);
    check("rst_slot", slot4, 2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef DEMUX_TDM_PARITY_EN
    // Frame 1,0,1,1 with correct even parity bit 1.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("par_wait_done", done4, 1'b0);
    check("par_wait_y",    y4,    4'b0000);
    step(1'b1, 1'b1, 1'b0);
    check("par_ok_y",    y4,    4'b1101);
    check("par_ok_done", done4, 1'b1);
    check("par_ok_err",  err4,  1'b0);
    check("par_ok_slot", slot4, 2'd0);
    // Frame 0,1,1,0 has even weight; a parity bit of 1 is a mismatch.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("par_bad_err",  err4,  1'b1);
    check("par_bad_done", done4, 1'b0);
    check("par_bad_y",    y4,    4'b1101);
    // sof arriving in the parity slot restarts the frame with an error.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("par_sof_err",  err4,  1'b1);
    check("par_sof_slot", slot4, 2'd1);
    check("par_sof_y",    y4,    4'b1101);
`else
    // Basic frame 1,0,1,1.
    step(1'b1, 1'b1, 1'b1);
    check("f1_slot1", slot4, 2'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("f1_slot3", slot4, 2'd3);
    check("f1_nodone", done4, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("f1_y",    y4,    4'b1101);
    check("f1_done", done4, 1'b1);
    check("f1_slot", slot4, 2'd0);
    check("f1_err",  err4,  1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("f1_done_pulse", done4, 1'b0);
    check("f1_y_hold",     y4,    4'b1101);

    // Early sof after two bits, then 1,1,0.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("es_err",  err4,  1'b1);
    check("es_slot", slot4, 2'd1);
    step(1'b1, 1'b1, 1'b0);
    check("es_err_pulse", err4, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("es_y",    y4,    4'b0110);
    check("es_done", done4, 1'b1);

    // Same 1,0,1,1 frame with a three-cycle valid gap before the last bit.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("gap_slot", slot4, 2'd3);
    check("gap_err",  err4,  1'b0);
    check("gap_y",    y4,    4'b0110);
    step(1'b1, 1'b1, 1'b0);
    check("gap_y_final", y4,    4'b1101);
    check("gap_done",    done4, 1'b1);

    // Reset in the middle of a frame clears outputs without waiting for a clock.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y",    y4,    4'b0000);
    check("mid_rst_slot", slot4, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("post_rst_y",    y4,    4'b1110);
    check("post_rst_done", done4, 1'b1);

    // N=5: two back-to-back frames exercising the non-power-of-two wrap.
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(bits5[i][0], 1'b1, (i == 0) || (i == 5));
      check($sformatf("n5_slot%0d", i), slot5, slot_exp[i]);
      done_cnt += int'(done5);
      if (i == 4) check("n5_y_a", y5, 5'b10011);
    end
    check("n5_y_b",     y5,       5'b01010);
    check("n5_done_ct", done_cnt, 2);
    check("n5_err",     err5,     1'b0);
`endif

    // Direct mode.
    do_reset();
    sel_mode = 1'b1;
    sel = 3'd2;
    step(1'b1, 1'b1, 1'b0);
    check("dir_y",    y4,    4'b0100);
    check("dir_done", done4, 1'b1);
    check("dir_slot", slot4, 2'd0);
    check("n3_dir_y", y3,    3'b100);
    sel = 3'd3;
    step(1'b1, 1'b1, 1'b0);
    check("n3_oor_err",  err3,  1'b1);
    check("n3_oor_done", done3, 1'b0);
    check("n3_oor_y",    y3,    3'b100);
    check("dir_sel3_y",  y4,    4'b1100);
    check("dir_sel3_err", err4, 1'b0);
    sel = 3'd0;
    step(1'b1, 1'b1, 1'b1);
    check("dir_sof_ign_y",    y4,    4'b1101);
    check("dir_sof_ign_slot", slot4, 2'd0);
    sel = 3'd1;
    step(1'b1, 1'b0, 1'b0);
    check("dir_idle_y",    y4,    4'b1101);
    check("dir_idle_done", done4, 1'b0);

    // Auto-to-direct switch mid-frame drops the partial frame silently.
    sel_mode = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("sw_slot_run", slot4, 2'd2);
    sel_mode = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("sw_slot", slot4, 2'd0);
    check("sw_err",  err4,  1'b0);
    check("sw_y",    y4,    4'b1101);
    sel_mode = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check("sw_drop_slot", slot4, 2'd0);
    check("sw_drop_y",    y4,    4'b1101);
    check("sw_drop_err",  err4,  1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
